// File: rtl/vga_seq_pkg.sv
// vga_seq_pkg: shared state encoding and constants for the scene sequencer
package vga_seq_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, FADE_OUT, FADE_IN} seq_state_t;
  localparam logic [3:0] FADE_MAX  = 4'd15;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h5A;
endpackage

// File: rtl/vga_frame_tick.sv
// vga_frame_tick: v_sync rising-edge detector (no tick until v_sync seen low after reset) and frame counter
module vga_frame_tick (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        v_sync,
  output logic        frame_tick,
  output logic [15:0] frame_count
);
  logic vs_q, armed;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      armed       <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      vs_q        <= v_sync;
      armed       <= armed | ~v_sync;
      frame_tick  <= v_sync & ~vs_q & armed;
      frame_count <= frame_tick ? frame_count + 1'b1 : frame_count;
    end
  end
endmodule

// File: rtl/vga_scene_sequencer.sv
// vga_scene_sequencer: frame-synchronous scene/fade scheduler; SEQ_SHUFFLE_EN selects LFSR scene order
module vga_scene_sequencer
  import vga_seq_pkg::*;
#(
  parameter int NUM_SCENES   = 4,
  parameter int SCENE_FRAMES = 240,
  parameter int SCENE_W      = 4,
  parameter int SFRAME_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                v_sync,
  input  logic                pause,
  input  logic                skip,
  output logic [SCENE_W-1:0]  scene,
  output logic [SCENE_W-1:0]  next_scene,
  output logic [SFRAME_W-1:0] scene_frame,
  output logic [3:0]          fade,
  output logic [15:0]         frame_count,
  output logic                frame_tick,
  output logic                in_transition
);
  localparam logic [SCENE_W-1:0]  LAST    = SCENE_W'(NUM_SCENES - 1);
  localparam logic [SFRAME_W-1:0] SF_LAST = SFRAME_W'(SCENE_FRAMES - 1);
  seq_state_t state, state_n;
  logic [SCENE_W-1:0]  scene_n, next_n, pick;
  logic [SFRAME_W-1:0] sf_n;
  logic [3:0]          fade_n;
  logic                skip_pend, pend_n, skip_eff, go;
  function automatic logic [SCENE_W-1:0] wrap_inc(input logic [SCENE_W-1:0] s);
    return (s == LAST) ? '0 : s + 1'b1;
  endfunction
  vga_frame_tick u_tick (
    .clk         (clk),
    .rst_n       (rst_n),
    .v_sync      (v_sync),
    .frame_tick  (frame_tick),
    .frame_count (frame_count)
  );
  assign in_transition = state != PLAY;
  assign skip_eff      = skip_pend | skip;
  assign go            = frame_tick & ~pause;
`ifdef SEQ_SHUFFLE_EN
  logic [7:0]         lfsr;
  logic [15:0]        lw;
  logic [SCENE_W-1:0] draw;
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else if (frame_tick) lfsr <= lfsr[0] ? (lfsr >> 1) ^ LFSR_TAPS : lfsr >> 1;
  end
  always_comb begin
    lw   = {8'd0, lfsr};
    draw = lw[SCENE_W-1:0];
    for (int i = 0; i < (1 << SCENE_W) / NUM_SCENES; i++)
      draw = (draw > LAST) ? draw - SCENE_W'(NUM_SCENES) : draw;
    pick = (draw == next_scene) ? wrap_inc(draw) : draw;
  end
`else
  assign pick = wrap_inc(next_scene);
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      scene       <= '0;
      next_scene  <= SCENE_W'(1);
      scene_frame <= '0;
      fade        <= 4'd0;
      skip_pend   <= 1'b0;
    end else begin
      state       <= state_n;
      scene       <= scene_n;
      next_scene  <= next_n;
      scene_frame <= sf_n;
      fade        <= fade_n;
      skip_pend   <= pend_n;
    end
  end
  always_comb begin
    state_n = state;
    scene_n = scene;
    next_n  = next_scene;
    sf_n    = scene_frame;
    fade_n  = fade;
    pend_n  = skip_eff;
    if (go) begin
      case (state)
        IDLE: begin
          state_n = FADE_IN;
          fade_n  = 4'd1;
        end
        FADE_IN: begin
          fade_n  = fade + 4'd1;
          pend_n  = 1'b0;
          state_n = (fade == FADE_MAX - 4'd1) ? PLAY : FADE_IN;
          sf_n    = (fade == FADE_MAX - 4'd1) ? '0 : scene_frame;
        end
        PLAY: begin
          state_n = (skip_eff || scene_frame == SF_LAST) ? FADE_OUT : PLAY;
          fade_n  = (skip_eff || scene_frame == SF_LAST) ? FADE_MAX - 4'd1 : fade;
          sf_n    = (skip_eff || scene_frame == SF_LAST) ? scene_frame : scene_frame + 1'b1;
          pend_n  = 1'b0;
        end
        FADE_OUT: begin
          pend_n  = 1'b0;
          state_n = (fade == 4'd0) ? FADE_IN : FADE_OUT;
          scene_n = (fade == 4'd0) ? next_scene : scene;
          next_n  = (fade == 4'd0) ? pick : next_scene;
          fade_n  = (fade == 4'd0) ? fade : fade - 4'd1;
        end
      endcase
    end
  end
endmodule
